instr_encoder_loader: RTL and testbench
=======================================

// Module: instr_encoder_loader
// PURPOSE
//  Encoder/writer counterpart to the opcode decoder. Accepts symbolic instructions
//  (kind + fields) over a valid/ready handshake and packs them into 32-bit MIPS words.
//  Writes the words sequentially into instruction memory from BASE_ADDR and always
//  terminates the program with the 0xFC000000 halt/dump word (opcode 6'b111111).
//  Sits between the testbench/program source and the imem write port, ahead of CPU reset release.
// PARAMETERS
//  ADDR_W     8   imem word-address width
//  DEPTH      256 program capacity in words, including the reserved halt slot (2..2**ADDR_W)
//  BASE_ADDR  0   first word address written
// PORTS
//  clk         in   1   rising-edge clock
//  rst_n       in   1   asynchronous active-low reset
//  start       in   1   1-cycle pulse: begin a new program load (honoured in IDLE/DONE only)
//  in_valid    in   1   instruction fields valid
//  in_ready    out  1   encoder can accept this cycle
//  in_kind     in   3   0 ADD(R), 1 ADDI, 2 LW, 3 SW, 4 BEQ, 5 J, 6 HALT, 7 illegal
//  in_rs       in   5   source register
//  in_rt       in   5   target register
//  in_rd       in   5   destination register (ADD only)
//  in_imm      in   16  immediate/offset (ADDI, LW, SW, BEQ)
//  in_target   in   26  jump target (J only)
//  imem_we     out  1   imem write strobe
//  imem_addr   out  ADDR_W  imem word address
//  imem_wdata  out  32  encoded instruction word
//  count       out  ADDR_W+1  words written this load, halt included
//  done        out  1   program complete (halt written); held until next start
//  overflow    out  1   sticky: capacity hit, auto-halt inserted
//  err         out  1   1-cycle pulse: illegal kind accepted and dropped
// BEHAVIOUR
//  Reset: state IDLE, all outputs 0, internal write pointer = BASE_ADDR.
//  States: IDLE -start-> LOAD; LOAD -halt written-> DONE; DONE -start-> LOAD.
//  On start: pointer = BASE_ADDR; count, done, overflow cleared.
//  in_ready = (state==LOAD) && (count < DEPTH-1) && !halt_pending.
//  Accept on in_valid&&in_ready at edge N; imem_we=1 for exactly the cycle after N.
//  addr/wdata are registered alongside it; pointer and count increment at edge N.
//  Back-to-back accepts sustain one write per cycle.
//  Encoding {op,rs,rt,rd,shamt,funct} / {op,rs,rt,imm} / {op,target}:
//   ADD  {6'h00,rs,rt,rd,5'd0,6'h20};  ADDI {6'h08,rs,rt,imm};  LW {6'h23,rs,rt,imm}
//   SW   {6'h2B,rs,rt,imm};  BEQ {6'h04,rs,rt,imm};  J {6'h02,target};  HALT 32'hFC000000
//  Unused fields for a kind are ignored, never leaked into the word.
//  HALT accepted: halt word written next cycle; done=1 and state DONE on that write edge.
//  Illegal kind (7) accepted: no write, count unchanged, err pulses 1 cycle, stays in LOAD.
//  Capacity: when count reaches DEPTH-1 in LOAD, in_ready drops. Next cycle the halt word is
//   auto-written at the last slot (BASE_ADDR+DEPTH-1); overflow=1, then done=1.
//  Pointer addition is modulo 2**ADDR_W (BASE_ADDR+DEPTH may wrap).
//  start while in LOAD is ignored. in_valid outside LOAD is ignored (in_ready=0).
//  Async reset mid-load: imem_we deasserts immediately, everything returns to reset values.
//  Already-written imem contents are untouched.
// TESTING
//  start; ADD rs=1 rt=2 rd=3 -> addr 0 wdata 32'h00221820, imem_we 1 cycle after accept.
//  ADDI rs=0 rt=1 imm=5 -> 32'h20010005; LW rs=1 rt=2 imm=4 -> 32'h8C220004.
//  Back-to-back: SW rs=1 rt=2 imm=8 -> 32'hAC220008 @1, then BEQ imm=16'hFFFF -> 32'h1022FFFF @2.
//  Continue: J target=26'h10 -> 32'h08000010 @3; HALT -> 32'hFC000000 @4, done=1, count=5.
//  DEPTH=4: stream 5 ADDs -> writes @0..2, in_ready low, halt auto @3, overflow=1, done=1.
//  Illegal kind=7 -> err pulse, no imem_we, count unchanged.
//  rst_n low mid-stream -> imem_we/done/count 0 at once; start then restarts at BASE_ADDR.

Source files
------------

// File: rtl/instr_encoder_loader.sv
// instr_encoder_loader
//   Packs symbolic instructions (kind + fields) into 32-bit MIPS words.
//   Writes them sequentially into instruction memory starting at BASE_ADDR.
//   Every load is terminated by the 0xFC000000 halt word. The halt word is
//   either requested explicitly or inserted automatically when capacity is hit.
//
// Ports
//   clk, rst_n            clock, asynchronous active-low reset
//   start                 begin a new load (only honoured in IDLE/DONE)
//   in_valid/in_ready     instruction handshake
//   in_kind               0 ADD, 1 ADDI, 2 LW, 3 SW, 4 BEQ, 5 J, 6 HALT, 7 illegal
//   in_rs/rt/rd/imm/target  instruction fields (unused ones ignored per kind)
//   imem_we/addr/wdata    registered imem write port, one cycle after accept
//   count                 words written this load, halt included
//   done                  halt written; held until next start
//   overflow              sticky: capacity hit, auto-halt inserted
//   err                   1-cycle pulse: illegal kind accepted and dropped
module instr_encoder_loader #(
  parameter int ADDR_W    = 8,
  parameter int DEPTH     = 256,
  parameter int BASE_ADDR = 0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [2:0]        in_kind,
  input  logic [4:0]        in_rs,
  input  logic [4:0]        in_rt,
  input  logic [4:0]        in_rd,
  input  logic [15:0]       in_imm,
  input  logic [25:0]       in_target,
  output logic              imem_we,
  output logic [ADDR_W-1:0] imem_addr,
  output logic [31:0]       imem_wdata,
  output logic [ADDR_W:0]   count,
  output logic              done,
  output logic              overflow,
  output logic              err
);

  typedef enum logic [1:0] {IDLE, LOAD, DONE} state_t;

  typedef enum logic [2:0] {
    K_ADD, K_ADDI, K_LW, K_SW, K_BEQ, K_J, K_HALT, K_ILL
  } kind_t;

  typedef struct packed {
    logic [2:0]  kind;
    logic [4:0]  rs;
    logic [4:0]  rt;
    logic [4:0]  rd;
    logic [15:0] imm;
    logic [25:0] target;
  } req_t;

  // Last usable count: one slot is always reserved for the halt word.
  localparam logic [ADDR_W:0]   LAST   = (ADDR_W+1)'(DEPTH - 1);
  localparam logic [ADDR_W-1:0] BASE   = ADDR_W'(BASE_ADDR);
  localparam logic [31:0]       HALT_W = 32'hFC000000;

  state_t            state;
  logic [ADDR_W-1:0] ptr;
  logic              halt_pending;
  req_t              req;
  logic [31:0]       enc_word;

  assign req = '{kind: in_kind, rs: in_rs, rt: in_rt, rd: in_rd,
                 imm: in_imm, target: in_target};

  assign in_ready = (state == LOAD) && (count < LAST) && !halt_pending;

  // Only the fields that belong to the kind reach the word.
  always_comb begin
    enc_word = HALT_W;
    case (kind_t'(req.kind))
      K_ADD:  enc_word = {6'h00, req.rs, req.rt, req.rd, 5'd0, 6'h20};
      K_ADDI: enc_word = {6'h08, req.rs, req.rt, req.imm};
      K_LW:   enc_word = {6'h23, req.rs, req.rt, req.imm};
      K_SW:   enc_word = {6'h2B, req.rs, req.rt, req.imm};
      K_BEQ:  enc_word = {6'h04, req.rs, req.rt, req.imm};
      K_J:    enc_word = {6'h02, req.target};
      default: enc_word = HALT_W;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= IDLE;
      ptr          <= BASE;
      count        <= '0;
      done         <= 1'b0;
      overflow     <= 1'b0;
      err          <= 1'b0;
      halt_pending <= 1'b0;
      imem_we      <= 1'b0;
      imem_addr    <= '0;
      imem_wdata   <= '0;
    end else begin
      imem_we <= 1'b0;
      err     <= 1'b0;
      case (state)
        IDLE, DONE: begin
          if (start) begin
            state    <= LOAD;
            ptr      <= BASE;
            count    <= '0;
            done     <= 1'b0;
            overflow <= 1'b0;
          end
        end
        LOAD: begin
          if (halt_pending) begin
            // Halt word is on the write port this cycle; load completes here.
            halt_pending <= 1'b0;
            done         <= 1'b1;
            state        <= DONE;
          end else if (count == LAST) begin
            // Capacity reached: force the halt into the reserved last slot.
            imem_we      <= 1'b1;
            imem_addr    <= ptr;
            imem_wdata   <= HALT_W;
            ptr          <= ptr + 1'b1;
            count        <= count + 1'b1;
            overflow     <= 1'b1;
            halt_pending <= 1'b1;
          end else if (in_valid && in_ready) begin
            if (kind_t'(req.kind) == K_ILL) begin
              err <= 1'b1;
            end else begin
              imem_we    <= 1'b1;
              imem_addr  <= ptr;
              imem_wdata <= enc_word;
              ptr        <= ptr + 1'b1;
              count      <= count + 1'b1;
              if (kind_t'(req.kind) == K_HALT) halt_pending <= 1'b1;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_instr_encoder_loader.sv
module tb_instr_encoder_loader;

  localparam int DEP  [2] = '{256, 4};
  localparam int BASEA[2] = '{0, 254};

  logic        clk = 1'b0, rst_n = 1'b0, st0 = 1'b0, st1 = 1'b0, vld = 1'b0;
  logic [2:0]  kind = '0;
  logic [4:0]  rs = '0, rt = '0, rd = '0;
  logic [15:0] imm = '0;
  logic [25:0] tgt = '0;

  logic        rdy[2], we[2], dn[2], ovf[2], er[2];
  logic [7:0]  addr[2];
  logic [31:0] wdata[2];
  logic [8:0]  cnt[2];

  logic [31:0] mem0[256];
  logic [31:0] mem1[256];

  int checks = 0;
  int fails  = 0;

  always #5 clk = ~clk;

  instr_encoder_loader #(.ADDR_W(8), .DEPTH(256), .BASE_ADDR(0)) u0 (
    .clk(clk), .rst_n(rst_n), .start(st0), .in_valid(vld), .in_ready(rdy[0]),
    .in_kind(kind), .in_rs(rs), .in_rt(rt), .in_rd(rd), .in_imm(imm), .in_target(tgt),
    .imem_we(we[0]), .imem_addr(addr[0]), .imem_wdata(wdata[0]), .count(cnt[0]),
    .done(dn[0]), .overflow(ovf[0]), .err(er[0]));

  instr_encoder_loader #(.ADDR_W(8), .DEPTH(4), .BASE_ADDR(254)) u1 (
    .clk(clk), .rst_n(rst_n), .start(st1), .in_valid(vld), .in_ready(rdy[1]),
    .in_kind(kind), .in_rs(rs), .in_rt(rt), .in_rd(rd), .in_imm(imm), .in_target(tgt),
    .imem_we(we[1]), .imem_addr(addr[1]), .imem_wdata(wdata[1]), .count(cnt[1]),
    .done(dn[1]), .overflow(ovf[1]), .err(er[1]));

  // Instruction memories as seen by the write ports
  initial for (int a = 0; a < 256; a++) begin mem0[a] = 32'hDEADBEEF; mem1[a] = 32'hDEADBEEF; end
  always @(posedge clk) begin
    if (we[0]) mem0[addr[0]] <= wdata[0];
    if (we[1]) mem1[addr[1]] <= wdata[1];
  end

  function automatic void chk(string nm, int i, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s[%0d] t=%0t got=%h expected=%h", nm, i, $time, act, exp);
    end
  endfunction

  // ---------------- behavioural model ----------------
  function automatic logic [31:0] enc(logic [2:0] k, logic [31:0] a_rs, logic [31:0] a_rt,
                                      logic [31:0] a_rd, logic [31:0] a_imm, logic [31:0] a_tg);
    logic [31:0] ri;
    ri = a_rs * 32'h200000 + a_rt * 32'h10000 + a_imm;
    case (k)
      3'd0: return a_rs * 32'h200000 + a_rt * 32'h10000 + a_rd * 32'h800 + 32'd32;
      3'd1: return 32'h08 * 32'h4000000 + ri;
      3'd2: return 32'h23 * 32'h4000000 + ri;
      3'd3: return 32'h2B * 32'h4000000 + ri;
      3'd4: return 32'h04 * 32'h4000000 + ri;
      3'd5: return 32'h02 * 32'h4000000 + a_tg;
      default: return 32'hFC000000;
    endcase
  endfunction

  bit          m_load[2], m_done[2], m_ovf[2], m_hp[2], m_we[2], m_err[2];
  int          m_cnt[2], m_ptr[2], m_addr[2];
  logic [31:0] m_data[2];

  function automatic bit m_rdy(int i);
    return m_load[i] && (m_cnt[i] < DEP[i] - 1) && !m_hp[i];
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 2; i++) begin
        m_load[i] = 0; m_done[i] = 0; m_ovf[i] = 0; m_hp[i] = 0; m_we[i] = 0; m_err[i] = 0;
        m_cnt[i] = 0; m_ptr[i] = BASEA[i]; m_addr[i] = 0; m_data[i] = '0;
      end
    end else begin
      for (int i = 0; i < 2; i++) begin
        bit go;
        go = m_rdy(i) && vld;
        m_we[i] = 0; m_err[i] = 0;
        if (m_hp[i]) begin
          m_hp[i] = 0; m_done[i] = 1; m_load[i] = 0;
        end else if (m_load[i] && m_cnt[i] == DEP[i] - 1) begin
          m_we[i] = 1; m_addr[i] = m_ptr[i]; m_data[i] = 32'hFC000000;
          m_ptr[i] = (m_ptr[i] + 1) % 256; m_cnt[i]++; m_ovf[i] = 1; m_hp[i] = 1;
        end else if (go) begin
          if (kind == 3'd7) m_err[i] = 1;
          else begin
            m_we[i] = 1; m_addr[i] = m_ptr[i];
            m_data[i] = enc(kind, 32'(rs), 32'(rt), 32'(rd), 32'(imm), 32'(tgt));
            m_ptr[i] = (m_ptr[i] + 1) % 256; m_cnt[i]++;
            if (kind == 3'd6) m_hp[i] = 1;
          end
        end else if (!m_load[i] && ((i == 0) ? st0 : st1)) begin
          m_load[i] = 1; m_ptr[i] = BASEA[i]; m_cnt[i] = 0; m_done[i] = 0; m_ovf[i] = 0;
        end
      end
    end
  end

  // Cycle-by-cycle compare against the model, away from the active edge
  always @(negedge clk) begin
    for (int i = 0; i < 2; i++) begin
      chk("in_ready", i, {31'b0, rdy[i]}, {31'b0, m_rdy(i)});
      chk("imem_we",  i, {31'b0, we[i]},  {31'b0, m_we[i]});
      if (m_we[i]) begin
        chk("imem_addr",  i, {24'b0, addr[i]}, 32'(m_addr[i]));
        chk("imem_wdata", i, wdata[i], m_data[i]);
      end
      chk("count",    i, {23'b0, cnt[i]}, 32'(m_cnt[i]));
      chk("done",     i, {31'b0, dn[i]},  {31'b0, m_done[i]});
      chk("overflow", i, {31'b0, ovf[i]}, {31'b0, m_ovf[i]});
      chk("err",      i, {31'b0, er[i]},  {31'b0, m_err[i]});
    end
  end

  // ---------------- stimulus ----------------
  task automatic cyc(); @(posedge clk); #2; endtask

  task automatic send(input logic [2:0] k, input int a, input int b, input int c,
                      input int im, input int tg);
    vld = 1'b1; kind = k; rs = 5'(a); rt = 5'(b); rd = 5'(c); imm = 16'(im); tgt = 26'(tg);
    cyc();
  endtask

  task automatic idle(input int n);
    vld = 1'b0;
    repeat (n) cyc();
  endtask

  task automatic pulse(input int i);
    if (i == 0) st0 = 1'b1; else st1 = 1'b1;
    cyc();
    st0 = 1'b0; st1 = 1'b0;
  endtask

  initial begin
    repeat (2) cyc();
    chk("rst_count", 0, {23'b0, cnt[0]}, 32'd0);
    chk("rst_we",    0, {31'b0, we[0]},  32'd0);
    chk("rst_ready", 0, {31'b0, rdy[0]}, 32'd0);
    rst_n = 1'b1;
    idle(1);

    // Load A: unused fields carry junk that must not leak
    pulse(0);
    send(3'd0, 1, 2, 3, 16'h1234, 26'h3FFFFFF);
    send(3'd1, 0, 1, 31, 5, 26'h3FFFFFF);
    send(3'd2, 1, 2, 9, 4, 26'h155);
    send(3'd6, 31, 31, 31, 16'hFFFF, 26'h3FFFFFF);
    idle(3);
    chk("A_add",  0, mem0[0], 32'h00221820);
    chk("A_addi", 0, mem0[1], 32'h20010005);
    chk("A_lw",   0, mem0[2], 32'h8C220004);
    chk("A_halt", 0, mem0[3], 32'hFC000000);
    chk("A_count", 0, {23'b0, cnt[0]}, 32'd4);
    chk("A_done",  0, {31'b0, dn[0]},  32'd1);

    // Load B: back-to-back SW/BEQ/J/HALT
    pulse(0);
    send(3'd0, 1, 2, 3, 0, 0);
    idle(1);
    send(3'd3, 1, 2, 0, 8, 0);
    send(3'd4, 1, 2, 0, 16'hFFFF, 0);
    send(3'd5, 7, 9, 11, 16'hABCD, 26'h10);
    send(3'd6, 0, 0, 0, 0, 0);
    idle(3);
    chk("B_sw",   0, mem0[1], 32'hAC220008);
    chk("B_beq",  0, mem0[2], 32'h1022FFFF);
    chk("B_j",    0, mem0[3], 32'h08000010);
    chk("B_halt", 0, mem0[4], 32'hFC000000);
    chk("B_count", 0, {23'b0, cnt[0]}, 32'd5);
    chk("B_done",  0, {31'b0, dn[0]},  32'd1);
    chk("B_ovf",   0, {31'b0, ovf[0]}, 32'd0);

    // Illegal kind, start ignored while loading, then async reset mid-stream
    pulse(0);
    send(3'd7, 1, 2, 3, 4, 5);
    chk("ill_err", 0, {31'b0, er[0]}, 32'd1);
    chk("ill_we",  0, {31'b0, we[0]}, 32'd0);
    idle(1);
    chk("ill_err_off", 0, {31'b0, er[0]},  32'd0);
    chk("ill_count",   0, {23'b0, cnt[0]}, 32'd0);
    send(3'd0, 4, 5, 6, 0, 0);
    idle(1);
    pulse(0);
    send(3'd0, 1, 1, 1, 0, 0);
    chk("midload_count", 0, {23'b0, cnt[0]}, 32'd2);
    chk("midload_we",    0, {31'b0, we[0]},  32'd1);
    #1 rst_n = 1'b0;
    #1;
    chk("arst_we",    0, {31'b0, we[0]},  32'd0);
    chk("arst_count", 0, {23'b0, cnt[0]}, 32'd0);
    chk("arst_done",  0, {31'b0, dn[0]},  32'd0);
    vld = 1'b0;
    cyc();
    rst_n = 1'b1;
    idle(1);
    chk("pre_restart_mem0", 0, mem0[0], 32'h00853020);
    pulse(0);
    send(3'd0, 7, 8, 9, 0, 0);
    idle(2);
    chk("restart_mem0",  0, mem0[0], 32'h00E84820);
    chk("restart_count", 0, {23'b0, cnt[0]}, 32'd1);
    send(3'd6, 0, 0, 0, 0, 0);
    idle(3);

    // Capacity on the DEPTH=4 instance, base 254 so the pointer wraps
    pulse(1);
    for (int j = 1; j <= 5; j++) send(3'd0, 1, 2, j, 0, 0);
    idle(4);
    chk("cap_w0",    1, mem1[254], 32'h00220820);
    chk("cap_w1",    1, mem1[255], 32'h00221020);
    chk("cap_w2",    1, mem1[0],   32'h00221820);
    chk("cap_halt",  1, mem1[1],   32'hFC000000);
    chk("cap_spare", 1, mem1[2],   32'hDEADBEEF);
    chk("cap_ovf",   1, {31'b0, ovf[1]}, 32'd1);
    chk("cap_done",  1, {31'b0, dn[1]},  32'd1);
    chk("cap_count", 1, {23'b0, cnt[1]}, 32'd4);
    chk("u0_untouched", 0, {23'b0, cnt[0]}, 32'd2);

    $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
    $finish;
  end

endmodule
